kmer_window_ctrl: RTL
=====================

Name: kmer_window_ctrl

Overview:
Sequences the 3-bit-per-base k-mer shift window of the alignment accelerator.
- Accepts a read as a valid/ready symbol stream after a start command.
- Shifts each symbol into a K-symbol window in the direction chosen at start.
- Presents each complete window, with its position, to the downstream seed comparator over a valid/ready handshake.
- Raises done when the whole read has been consumed.

Parameters:
SYM_W, 3, bits per nucleotide symbol
K, 4, symbols per window; window width is K*SYM_W
LEN_W, 16, width of the sequence-length and position counters

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-low; reset==0 at posedge clears all state
start  in  1  command pulse, honoured only in IDLE
dir  in  1  sampled on start; 1 = new symbol enters at LSB, 0 = new symbol enters at MSB
seq_len  in  LEN_W  number of symbols to consume, sampled on start
sym_in  in  SYM_W  symbol data
sym_valid  in  1  symbol available
sym_ready  out  1  controller accepts symbol
win_out  out  K*SYM_W  current window
win_valid  out  1  window complete and held
win_ready  in  1  consumer accepts window
win_pos  out  LEN_W  0-based index of newest symbol in win_out
busy  out  1  high in FILL and EMIT
done  out  1  one-cycle pulse at end of read

Behaviour:
- Reset values: win_out=0, win_pos=0, win_valid=0, sym_ready=0, busy=0, done=0, state=IDLE, counters=0. Reset mid-operation aborts immediately; no done pulse is issued.
- FSM states: IDLE, FILL, EMIT, DONE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE on start:
  - Latch dir and seq_len; clear window, fill_cnt and consumed.
  - If seq_len < K, go to DONE (zero windows). Otherwise go to FILL.
  - start while busy or in DONE is ignored.
- FILL:
  - sym_ready=1.
  - On sym_valid&&sym_ready:
    - dir=1: window <= {window[K*SYM_W-SYM_W-1:0], sym_in}.
    - dir=0: window <= {sym_in, window[K*SYM_W-1:SYM_W]}.
    - consumed++; fill_cnt++, saturating at K; win_pos <= consumed (the pre-increment value).
    - If the post-increment fill_cnt == K, go to EMIT.
- EMIT:
  - win_valid=1, sym_ready=0.
  - win_out and win_pos are held stable until win_ready.
  - On win_valid&&win_ready: if consumed == seq_len, go to DONE; else go to FILL with fill_cnt kept at K, so exactly one more symbol yields the next window.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. win_out keeps its last value.
- Throughput: at most one window per 2 cycles. Window count is seq_len-K+1 for seq_len >= K.
- Counter width: consumed is LEN_W bits and compared for equality only; seq_len = 2^LEN_W-1 is the maximum.

Optional Feature:
Macro SKIP_AMBIG_EN.
- Defined:
  - An accepted symbol equal to SYM_N (3'b100) increments consumed, clears the window to 0 and sets fill_cnt=0, so no emitted window contains N.
  - If any accepted symbol in FILL makes consumed == seq_len with fill_cnt < K, go directly to DONE.
- Undefined: N is shifted like any other symbol, and only the EMIT-exit check exists.

Decomposition:
- Shared package: symbol encodings SYM_A=0, SYM_C=1, SYM_G=2, SYM_T=3, SYM_N=4; FSM state enum; default SYM_W/K.
- One natural sub-module: kmer_window_shift. It holds the window register and implements shift, clear and dir select, with enable, clear, dir and sym ports.
- The FSM and counters stay in kmer_window_ctrl.

Test Plan:
- dir=1, seq_len=5, stream A C G T A, win_ready=1 -> window 1: win_out=0x053, win_pos=3. Window 2: win_out=0x298, win_pos=4. Then one done pulse; exactly 2 windows.
- dir=0, same stream -> window 1: 0x688, pos 3. Window 2: 0x0D1, pos 4.
- Backpressure: hold win_ready=0 for 3 cycles during the first window -> win_out/win_pos stable, sym_ready=0, no symbol consumed. Handshake completes on cycle 4.
- seq_len=3 with start -> done high the cycle after start, win_valid never asserted, sym_ready never asserted. seq_len=0 behaves the same.
- Stream A C N G T A C, seq_len=7:
  - With SKIP_AMBIG_EN: single window 0x4C1 at pos 6.
  - Without it: 4 windows at pos 3..6.
- reset=0 for one cycle while in EMIT -> next cycle win_valid=0, busy=0, win_out=0, no done pulse. A new start then runs normally.

Source files
------------

// File: rtl/kmer_window_ctrl_pkg.sv
// Shared definitions for the k-mer window controller.
// Contents: nucleotide symbol encodings, default parameter values,
// the controller FSM state type and a small symbol classification helper.
// The optional ambiguous-base skipping feature is enabled by defining
// the macro SKIP_AMBIG_EN when building kmer_window_ctrl.
package kmer_window_ctrl_pkg;

    localparam int DEF_SYM_W = 3;
    localparam int DEF_K     = 4;
    localparam int DEF_LEN_W = 16;

    localparam logic [2:0] SYM_A = 3'd0;
    localparam logic [2:0] SYM_C = 3'd1;
    localparam logic [2:0] SYM_G = 3'd2;
    localparam logic [2:0] SYM_T = 3'd3;
    localparam logic [2:0] SYM_N = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // True when the symbol is the ambiguous base N.
    function automatic logic is_sym_n(input logic [2:0] sym);
        return (sym == SYM_N);
    endfunction

endpackage

// File: rtl/kmer_window_shift.sv
// K-symbol shift window register.
// Ports:
//   clk, reset : clock and synchronous active-low reset
//   en         : shift sym into the window this cycle
//   clr        : clear the window to zero (has priority over en)
//   dir        : 1 = new symbol enters at LSB, 0 = new symbol enters at MSB
//   sym        : symbol to shift in
//   win        : registered window contents
module kmer_window_shift
    import kmer_window_ctrl_pkg::*;
#(
    parameter int SYM_W = DEF_SYM_W,
    parameter int K     = DEF_K
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 dir,
    input  logic [SYM_W-1:0]     sym,
    output logic [K*SYM_W-1:0]   win
);

    localparam int WIN_W = K * SYM_W;

    logic [WIN_W-1:0] win_r;

    // Window register: clear wins over shift; direction picks the entry end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_r <= {WIN_W{1'b0}};
        end else if (clr) begin
            win_r <= {WIN_W{1'b0}};
        end else if (en) begin
            if (dir) begin
                win_r <= {win_r[WIN_W-SYM_W-1:0], sym};
            end else begin
                win_r <= {sym, win_r[WIN_W-1:SYM_W]};
            end
        end else begin
            win_r <= win_r;
        end
    end

    assign win = win_r;

endmodule

// File: rtl/kmer_window_ctrl.sv
// K-mer window sequencer for the alignment accelerator.
// After a start pulse it consumes seq_len symbols over a valid/ready stream,
// shifts them into a K-symbol window and hands each complete window, with the
// 0-based position of its newest symbol, to the seed comparator.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start, dir, seq_len : command; dir/seq_len sampled when start is seen in IDLE
//   sym_in, sym_valid, sym_ready : symbol input stream
//   win_out, win_pos, win_valid, win_ready : window output stream
//   busy                : high while filling or emitting
//   done                : one-cycle pulse when the read is finished
// Optional build macro SKIP_AMBIG_EN: an accepted N symbol restarts the
// window, so no emitted window ever contains N.
module kmer_window_ctrl
    import kmer_window_ctrl_pkg::*;
#(
    parameter int SYM_W = DEF_SYM_W,
    parameter int K     = DEF_K,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dir,
    input  logic [LEN_W-1:0]     seq_len,
    input  logic [SYM_W-1:0]     sym_in,
    input  logic                 sym_valid,
    output logic                 sym_ready,
    output logic [K*SYM_W-1:0]   win_out,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [LEN_W-1:0]     win_pos,
    output logic                 busy,
    output logic                 done
);

    localparam int               CNT_W     = $clog2(K + 1);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(K);
    localparam logic [CNT_W-1:0] FILL_ZERO = {CNT_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_K     = LEN_W'(K);
    localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1'b1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               dir_r;
    logic [LEN_W-1:0]   seq_len_r;
    logic [LEN_W-1:0]   consumed_r;
    logic [LEN_W-1:0]   win_pos_r;
    logic [CNT_W-1:0]   fill_cnt_r;
    logic [LEN_W-1:0]   consumed_inc_s;
    logic [CNT_W-1:0]   fill_inc_s;
    logic [CNT_W-1:0]   fill_nxt_s;
    logic               start_go_s;
    logic               accept_s;
    logic               ambig_s;
    logic               win_clr_s;
    logic               sym_ready_s;
    logic               win_valid_s;
    logic               busy_s;
    logic               done_s;

    assign start_go_s = (state_r == ST_IDLE) && start;
    assign accept_s   = (state_r == ST_FILL) && sym_valid;

`ifdef SKIP_AMBIG_EN
    assign ambig_s = is_sym_n(sym_in);
`else
    assign ambig_s = 1'b0;
`endif

    // A new command clears the window; an accepted N restarts it.
    assign win_clr_s = start_go_s || (accept_s && ambig_s);

    // Counter increments; fill count saturates at K and restarts on N.
    always_comb begin
        consumed_inc_s = consumed_r + LEN_ONE;
        if (fill_cnt_r == FILL_FULL) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_cnt_r + CNT_W'(1'b1);
        end
        if (ambig_s) begin
            fill_nxt_s = FILL_ZERO;
        end else begin
            fill_nxt_s = fill_inc_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (seq_len < LEN_K) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    if (fill_nxt_s == FILL_FULL) begin
                        state_nxt_s = ST_EMIT;
`ifdef SKIP_AMBIG_EN
                    end else if (consumed_inc_s == seq_len_r) begin
                        // Read ran out before another full window could form.
                        state_nxt_s = ST_DONE;
`endif
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_EMIT: begin
                if (win_ready) begin
                    if (consumed_r == seq_len_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode; depends on the state register only.
    always_comb begin
        sym_ready_s = 1'b0;
        win_valid_s = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_FILL: begin
                sym_ready_s = 1'b1;
                busy_s      = 1'b1;
            end
            ST_EMIT: begin
                win_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Command latch and read counters. win_pos takes the pre-increment count,
    // i.e. the index of the symbol just shifted in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dir_r      <= 1'b0;
            seq_len_r  <= LEN_ZERO;
            consumed_r <= LEN_ZERO;
            fill_cnt_r <= FILL_ZERO;
            win_pos_r  <= LEN_ZERO;
        end else if (start_go_s) begin
            dir_r      <= dir;
            seq_len_r  <= seq_len;
            consumed_r <= LEN_ZERO;
            fill_cnt_r <= FILL_ZERO;
        end else if (accept_s) begin
            consumed_r <= consumed_inc_s;
            fill_cnt_r <= fill_nxt_s;
            win_pos_r  <= consumed_r;
        end
    end

    kmer_window_shift #(
        .SYM_W (SYM_W),
        .K     (K)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .en    (accept_s),
        .clr   (win_clr_s),
        .dir   (dir_r),
        .sym   (sym_in),
        .win   (win_out)
    );

    assign sym_ready = sym_ready_s;
    assign win_valid = win_valid_s;
    assign busy      = busy_s;
    assign done      = done_s;
    assign win_pos   = win_pos_r;

endmodule
